bmem_arbiter: RTL and testbench
===============================

Name: bmem_arbiter

Overview:
- Sits inside mp4 between the I-cache/D-cache line-miss ports and the top-level bmem_* pins that drive burst_memory.
- Arbitrates two 256-bit cacheline clients onto the single burst memory port.
- Serializes write lines into 4 × 64-bit beats and assembles read beats back into a full line.
- Returns a one-cycle response to the winning client.

Parameters:
- ADDR_W, 32, byte-address width.
- BEAT_W, 64, burst memory data width.
- BEATS, 4, beats per cacheline; line width = BEAT_W*BEATS = 256.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_read  in  1  I-cache line read request, held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  256  assembled line for the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request, held until d_resp.
- d_write  in  1  D-cache line writeback request, held until d_resp; never asserted together with d_read.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  256  D-cache writeback line.
- d_rdata  out  256  assembled line for the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- bmem_address  out  ADDR_W  burst address, line-aligned: {addr[ADDR_W-1:5],5'b0}.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat data.
- bmem_rdata  in  BEAT_W  read beat data.
- bmem_resp  in  1  read beat valid.

Behaviour:
- Reset values: all outputs are 0, FSM is in IDLE, beat counter is 0, line buffer is 0, grant is none, rr pointer selects D.
- FSM states: IDLE, RD_REQ, RD_BEAT, WR_BEAT, RESP.
- IDLE:
  - Sample requests and register the grant.
  - Fixed priority: D over I.
  - D with d_write goes to WR_BEAT; any read goes to RD_REQ.
  - No request: stay in IDLE.
- RD_REQ:
  - bmem_read=1 and bmem_address valid for exactly one cycle, then go to RD_BEAT.
- RD_BEAT:
  - On each bmem_resp cycle, store bmem_rdata into line slice [64*cnt +: 64] and increment cnt.
  - Beats need not be contiguous; cycles with bmem_resp=0 are held.
  - When the 4th beat (cnt==3 with resp) is stored, go to RESP.
- WR_BEAT:
  - bmem_write=1 for 4 consecutive cycles, with bmem_address constant.
  - bmem_wdata = d_wdata[64*cnt +: 64], cnt 0..3.
  - Burst memory gives no bmem_resp for writes.
  - After beat 3, go to RESP.
- RESP:
  - Assert the granted client's resp for exactly one cycle.
  - For a read, the granted client's rdata equals the assembled line that same cycle. rdata stays registered until the next completion for that client.
  - Clear cnt and go to IDLE.
  - A client re-requesting in the cycle after resp is legal and is arbitrated normally.
- Latency:
  - Read: resp appears 1 cycle after the cycle the last beat arrives. Minimum total 6 cycles from IDLE grant with contiguous beats.
  - Write: exactly 6 cycles (IDLE, 4 beats, RESP).
- Simultaneous i_read and d_read/d_write in IDLE: D wins. I stays pending with no loss and is served on the next IDLE visit.
- A request dropped mid-transaction is illegal per client contract; the arbiter completes the burst regardless.
- Stray bmem_resp outside RD_BEAT is ignored.
- cnt is 2 bits and wraps 3→0 only on the transition out of beat states.
- rst asserted mid-burst immediately returns all outputs to their reset values. No resp is issued for the aborted transaction.

Optional Feature:
- Macro: BMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit rr pointer flips to the other client after each completion.
  - On conflict, the client the pointer selects wins.
  - Without conflict, the sole requester wins.
- Undefined: fixed D-over-I priority as above; the rr pointer logic is absent.

Decomposition:
- Shared package mp4_types gets:
  - the arb_state_t enum (IDLE, RD_REQ, RD_BEAT, WR_BEAT, RESP);
  - the client_t enum (CL_NONE, CL_I, CL_D);
  - localparams LINE_W=256 and OFFSET_W=5.
- One sub-module, line_deserializer: beat counter plus 256-bit shift/slot buffer, loading on bmem_resp and flagging last beat. The FSM and arbitration stay in bmem_arbiter.

Test Plan:
- I read, address 0x6000_0024 → bmem_address=0x6000_0020 with bmem_read high 1 cycle. Beats 0x11..,0x22..,0x33..,0x44.. are placed low→high in i_rdata. i_resp pulses once, 6 cycles after grant.
- D write, address 0x6000_1000, d_wdata = {64'hD,64'hC,64'hB,64'hA} → 4 consecutive bmem_write cycles carrying A,B,C,D at a constant address. d_resp follows 1 cycle later; no i_resp.
- i_read and d_read asserted in the same cycle → D is served first and I second, with no dropped request. With BMEM_ARB_RR_EN and the previous winner D, I is served first.
- Read with gaps: bmem_resp pattern 1,0,0,1,1,0,1 → line correct, and resp arrives 1 cycle after the 4th beat.
- rst pulsed during beat 2 of a write → bmem_write=0 immediately, FSM in IDLE, no d_resp. A re-issued write then completes with 4 beats.
- Stray bmem_resp in IDLE with data 0xDEAD → i_rdata and d_rdata are unchanged and no resp is issued.

Source files
------------

// File: rtl/mp4_types_pkg.sv
// Shared mp4 types: arbiter FSM states, client ids, cacheline geometry.
package mp4_types;
  localparam int LINE_W = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEAT,
    WR_BEAT,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    CL_NONE,
    CL_I,
    CL_D
  } client_t;
endpackage

// File: rtl/line_deserializer.sv
// Beat counter plus line buffer; slots beats into a cacheline.
module line_deserializer
  import mp4_types::*;
#(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  parameter int CW     = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    step,
  input  logic [BEAT_W-1:0]       beat,
  output logic [CW-1:0]           cnt,
  output logic                    last,
  output logic [LINE_W-1:0]       line
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      line <= '0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (load || step)
        cnt <= cnt + CW'(1);
      if (load)
        line[BEAT_W*cnt +: BEAT_W] <= beat;
    end
  end

  assign last = (cnt == CW'(BEATS-1));

endmodule

// File: rtl/bmem_arbiter.sv
// I/D cacheline arbiter onto the burst memory port.
// Build option: BMEM_ARB_RR_EN selects round-robin instead of D-first.
module bmem_arbiter
  import mp4_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  localparam int CW = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] AMASK =
    ~ADDR_W'((1 << OFFSET_W) - 1);

  arb_state_t state, state_d;
  client_t grant, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic rd_q, rd_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic [CW-1:0] cnt;
  logic last, load, step, clr;
  logic [LINE_W-1:0] line;
  logic d_req, pick_d;

  assign d_req = d_read | d_write;

`ifdef BMEM_ARB_RR_EN
  // rr_q=1 favours D; points at the other client after a completion
  logic rr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_q <= 1'b1;
    else if (state == RESP)
      rr_q <= (grant != CL_D);
  end
  assign pick_d = d_req && (!i_read || rr_q);
`else
  assign pick_d = d_req;
`endif

  line_deserializer #(
    .BEAT_W(BEAT_W),
    .BEATS (BEATS),
    .CW    (CW)
  ) u_deser (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .load(load),
    .step(step),
    .beat(bmem_rdata),
    .cnt (cnt),
    .last(last),
    .line(line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= CL_NONE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      addr_q <= addr_d;
      rd_q   <= rd_d;
      if (state == RESP && grant == CL_I)
        i_rdata_q <= line;
      if (state == RESP && grant == CL_D && rd_q)
        d_rdata_q <= line;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    addr_d       = addr_q;
    rd_d         = rd_q;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_wdata   = '0;
    bmem_address = '0;
    load         = 1'b0;
    step         = 1'b0;
    clr          = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_d) begin
          grant_d = CL_D;
          addr_d  = d_addr;
          rd_d    = !d_write;
          state_d = d_write ? WR_BEAT : RD_REQ;
        end else if (i_read) begin
          grant_d = CL_I;
          addr_d  = i_addr;
          rd_d    = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read    = 1'b1;
        bmem_address = addr_q & AMASK;
        state_d      = RD_BEAT;
      end
      RD_BEAT: begin
        load = bmem_resp;
        if (bmem_resp && last)
          state_d = RESP;
      end
      WR_BEAT: begin
        bmem_write   = 1'b1;
        bmem_address = addr_q & AMASK;
        bmem_wdata   = d_wdata[BEAT_W*cnt +: BEAT_W];
        step         = 1'b1;
        if (last)
          state_d = RESP;
      end
      RESP: begin
        i_resp  = (grant == CL_I);
        d_resp  = (grant == CL_D);
        clr     = 1'b1;
        grant_d = CL_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // read data is visible in the RESP cycle itself, then held
  assign i_rdata = (state == RESP && grant == CL_I)
                 ? line : i_rdata_q;
  assign d_rdata = (state == RESP && grant == CL_D && rd_q)
                 ? line : d_rdata_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed self-checking bench for bmem_arbiter.
module tb_bmem_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_address(bmem_address),
    .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata),
    .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // from RD_REQ: advance to RD_BEAT and feed 4 contiguous beats
  task automatic feed4(input logic [255:0] ln);
    tick();
    for (int k = 0; k < 4; k++) begin
      bmem_resp  = 1'b1;
      bmem_rdata = ln[64*k +: 64];
      tick();
    end
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
  endtask

  localparam logic [255:0] L_I = {64'h4444_4444_4444_4444,
                                  64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222,
                                  64'h1111_1111_1111_1111};
  localparam logic [255:0] W_D = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [255:0] L_C = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
  localparam logic [255:0] L_J = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
  localparam logic [255:0] L_G = {64'h9004, 64'h9003,
                                  64'h9002, 64'h9001};

  initial begin
    logic [6:0]   pat;
    logic [255:0] gap_line;
    logic [255:0] prev_i;
    logic [255:0] prev_d;
    logic         rr;
    int           k;
`ifdef BMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    // reset state
    tick();
    tick();
    chk("rst_bmem_read", 256'(bmem_read), 256'(0));
    chk("rst_bmem_write", 256'(bmem_write), 256'(0));
    chk("rst_addr", 256'(bmem_address), 256'(0));
    chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
    chk("rst_i_rdata", i_rdata, 256'(0));
    chk("rst_d_rdata", d_rdata, 256'(0));
    rst = 1'b0;
    tick();

    // I read with unaligned address
    i_read = 1'b1;
    i_addr = 32'h6000_0024;
    tick();
    chk("ird_req", 256'(bmem_read), 256'(1));
    chk("ird_addr", 256'(bmem_address), 256'(32'h6000_0020));
    tick();
    chk("ird_req_1cyc", 256'(bmem_read), 256'(0));
    for (k = 0; k < 4; k++) begin
      chk("ird_no_early_resp", 256'(i_resp), 256'(0));
      bmem_resp  = 1'b1;
      bmem_rdata = L_I[64*k +: 64];
      tick();
    end
    bmem_resp = 1'b0;
    chk("ird_resp", 256'(i_resp), 256'(1));
    chk("ird_line", i_rdata, L_I);
    i_read = 1'b0;
    tick();
    chk("ird_resp_pulse", 256'(i_resp), 256'(0));
    chk("ird_line_hold", i_rdata, L_I);

    // D write, 4 beats at constant address
    d_write = 1'b1;
    d_addr  = 32'h6000_1000;
    d_wdata = W_D;
    tick();
    for (k = 0; k < 4; k++) begin
      chk("dwr_valid", 256'(bmem_write), 256'(1));
      chk("dwr_addr", 256'(bmem_address), 256'(32'h6000_1000));
      chk("dwr_data", 256'(bmem_wdata), 256'(W_D[64*k +: 64]));
      chk("dwr_no_resp", 256'(d_resp), 256'(0));
      tick();
    end
    chk("dwr_write_done", 256'(bmem_write), 256'(0));
    chk("dwr_resp", 256'(d_resp), 256'(1));
    chk("dwr_no_i_resp", 256'(i_resp), 256'(0));
    chk("dwr_d_rdata_kept", d_rdata, 256'(0));
    d_write = 1'b0;
    tick();

    // simultaneous I and D reads
    i_read = 1'b1;
    i_addr = 32'h6000_3000;
    d_read = 1'b1;
    d_addr = 32'h6000_2040;
    tick();
    chk("conf_first_addr", 256'(bmem_address),
        rr ? 256'(32'h6000_3000) : 256'(32'h6000_2040));
    feed4(rr ? L_J : L_C);
    chk("conf_first_i_resp", 256'(i_resp), 256'(rr));
    chk("conf_first_d_resp", 256'(d_resp), 256'(!rr));
    if (rr) begin
      chk("conf_first_line", i_rdata, L_J);
      i_read = 1'b0;
    end else begin
      chk("conf_first_line", d_rdata, L_C);
      d_read = 1'b0;
    end
    tick();
    tick();
    chk("conf_second_req", 256'(bmem_read), 256'(1));
    chk("conf_second_addr", 256'(bmem_address),
        rr ? 256'(32'h6000_2040) : 256'(32'h6000_3000));
    feed4(rr ? L_C : L_J);
    chk("conf_second_i_resp", 256'(i_resp), 256'(!rr));
    chk("conf_second_d_resp", 256'(d_resp), 256'(rr));
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    chk("conf_i_line", i_rdata, L_J);
    chk("conf_d_line", d_rdata, L_C);

    // D read with gaps in the beat stream
    d_read = 1'b1;
    d_addr = 32'h6000_4000;
    tick();
    tick();
    pat = 7'b1011001;
    k = 0;
    for (int p = 0; p < 7; p++) begin
      chk("gap_no_early_resp", 256'(d_resp), 256'(0));
      bmem_resp = pat[p];
      if (pat[p]) begin
        bmem_rdata = L_G[64*k +: 64];
        k++;
      end else begin
        bmem_rdata = 64'hBAD0_BAD0;
      end
      tick();
    end
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    chk("gap_resp", 256'(d_resp), 256'(1));
    chk("gap_line", d_rdata, L_G);
    d_read = 1'b0;
    tick();

    // stray bmem_resp while idle
    prev_i = i_rdata;
    prev_d = d_rdata;
    gap_line = L_G;
    bmem_resp  = 1'b1;
    bmem_rdata = 64'hDEAD;
    tick();
    chk("stray_no_resp", 256'({i_resp, d_resp}), 256'(0));
    tick();
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    tick();
    chk("stray_no_read", 256'(bmem_read), 256'(0));
    chk("stray_i_rdata", i_rdata, L_J);
    chk("stray_d_rdata", d_rdata, gap_line);
    chk("stray_held_i", i_rdata, prev_i);
    chk("stray_held_d", d_rdata, prev_d);

    // reset during write beat 2, then re-issued write
    d_write = 1'b1;
    d_addr  = 32'h6000_5000;
    d_wdata = W_D;
    tick();
    tick();
    tick();
    chk("rstmid_beat2", 256'(bmem_wdata), 256'(64'hC));
    rst = 1'b1;
    #1;
    chk("rstmid_write_off", 256'(bmem_write), 256'(0));
    chk("rstmid_no_resp", 256'(d_resp), 256'(0));
    tick();
    chk("rstmid_idle", 256'({bmem_read, bmem_write}), 256'(0));
    rst = 1'b0;
    tick();
    for (k = 0; k < 4; k++) begin
      chk("rewr_valid", 256'(bmem_write), 256'(1));
      chk("rewr_data", 256'(bmem_wdata), 256'(W_D[64*k +: 64]));
      chk("rewr_addr", 256'(bmem_address), 256'(32'h6000_5000));
      tick();
    end
    chk("rewr_resp", 256'(d_resp), 256'(1));
    d_write = 1'b0;
    tick();
    chk("rewr_resp_pulse", 256'(d_resp), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
